// File: rtl/microgreen_pkg.sv
// microgreen_pkg: RGB565 field positions, tiler FSM states and the green-pixel classifier
package microgreen_pkg;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  typedef enum logic [1:0] {IDLE, CAPTURE, EVAL, HOLD} state_e;

  // Green when G beats both doubled R and doubled B by the margin; 5-bit R/B are doubled
  // to match the 6-bit G scale, and the sums carry one spare bit so they cannot wrap.
  function automatic logic is_green(input logic [15:0] px, input logic [6:0] margin);
    logic [7:0] g, r_lim, b_lim;
    g     = {2'b00, px[G_MSB:G_LSB]};
    r_lim = {2'b00, px[R_MSB:R_LSB], 1'b0} + {1'b0, margin};
    b_lim = {2'b00, px[B_MSB:B_LSB], 1'b0} + {1'b0, margin};
    return (g >= r_lim) && (g >= b_lim);
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// cam_sync_edge: 2-FF synchronizer with registered rise/fall pulses and an aligned level
module cam_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sh_q;
  logic       rise_q, fall_q;

  // sh_q[1:0] is the synchronizer, sh_q[2] the previous sample; pulses land with sh_q[2]
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sh_q   <= {sh_q[1:0], d_i};
      rise_q <= sh_q[1] & ~sh_q[2];
      fall_q <= ~sh_q[1] & sh_q[2];
    end
  end

  assign lvl_o  = sh_q[2];
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/cam_green_tiler.sv
// cam_green_tiler: camera RGB565 capture, per-tile green counting, binarised feature vector (option: CAM_GREEN_STATS_EN)
module cam_green_tiler
  import microgreen_pkg::*;
#(
  parameter int IMG_W        = 160,
  parameter int IMG_H        = 120,
  parameter int TILES_X      = 4,
  parameter int TILES_Y      = 4,
  parameter int GREEN_MARGIN = 4,
  parameter int TILE_MIN     = 600
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 cam_data,
  input  logic                       cam_pclk,
  input  logic                       cam_href,
  input  logic                       cam_vsync,
  output logic [TILES_X*TILES_Y-1:0] feat_bits,
  output logic                       feat_valid,
  input  logic                       feat_ready,
  output logic                       frame_err
`ifdef CAM_GREEN_STATS_EN
  ,
  output logic [15:0]                green_total
`endif
);

  localparam int TW  = IMG_W / TILES_X;
  localparam int TH  = IMG_H / TILES_Y;
  localparam int NT  = TILES_X * TILES_Y;
  localparam int CW  = $clog2(TW * TH + 1);
  localparam int XW  = $clog2(TW + 1);
  localparam int YW  = $clog2(TH + 1);
  localparam int CXW = $clog2(TILES_X + 1);
  localparam int CYW = $clog2(TILES_Y + 1);
  localparam logic [XW-1:0]  XI_MAX = XW'(TW - 1);
  localparam logic [YW-1:0]  YI_MAX = YW'(TH - 1);
  localparam logic [CXW-1:0] TX_MAX = CXW'(TILES_X - 1);
  localparam logic [CYW-1:0] TY_MAX = CYW'(TILES_Y - 1);

  logic pclk_lvl, pclk_rise, pclk_fall;
  logic href_lvl, href_rise, href_fall;
  logic vs_lvl, vs_rise, vs_fall;
  logic unused;

  cam_sync_edge u_pclk (.clk(clk), .rst(rst), .d_i(cam_pclk),
                        .lvl_o(pclk_lvl), .rise_o(pclk_rise), .fall_o(pclk_fall));
  cam_sync_edge u_href (.clk(clk), .rst(rst), .d_i(cam_href),
                        .lvl_o(href_lvl), .rise_o(href_rise), .fall_o(href_fall));
  cam_sync_edge u_vs   (.clk(clk), .rst(rst), .d_i(cam_vsync),
                        .lvl_o(vs_lvl), .rise_o(vs_rise), .fall_o(vs_fall));

  assign unused = ^{pclk_lvl, pclk_fall, vs_lvl};

  state_e          state_q;
  logic [7:0]      d1_q, d2_q, d3_q, hi_q;
  logic            phase_q, line_px_q;
  logic [XW-1:0]   xi_q;
  logic [YW-1:0]   yi_q;
  logic [CXW-1:0]  tx_q;
  logic [CYW-1:0]  ty_q;
  logic            x_done_q, y_done_q;
  logic [CW-1:0]   cnt_q [NT];
  logic [NT-1:0]   bits_q, bits_d;
  logic            valid_q, err_q;
  logic            start, take, first, in_range, green, xi_last, yi_last, tx_last, ty_last;
  int              tile_idx;
`ifdef CAM_GREEN_STATS_EN
  logic [15:0]     tot_q, tot_out_q;
`endif

  assign start    = (state_q == IDLE) && vs_fall;
  assign take     = pclk_rise && href_lvl;
  assign first    = href_rise || !phase_q;
  assign in_range = !x_done_q && !y_done_q;
  assign green    = is_green({hi_q, d3_q}, 7'(GREEN_MARGIN));
  assign xi_last  = xi_q == XI_MAX;
  assign yi_last  = yi_q == YI_MAX;
  assign tx_last  = tx_q == TX_MAX;
  assign ty_last  = ty_q == TY_MAX;
  assign tile_idx = int'(ty_q) * TILES_X + int'(tx_q);

  // Byte delay matching the three-stage PCLK path, so the byte seen on a rise pulse was stable at the pin
  always_ff @(posedge clk) begin
    if (rst) begin
      d1_q <= '0;
      d2_q <= '0;
      d3_q <= '0;
    end else begin
      d1_q <= cam_data;
      d2_q <= d1_q;
      d3_q <= d2_q;
    end
  end

  // Pixel assembly, position tracking and per-tile green counting; a frame start clears everything
  always_ff @(posedge clk) begin
    if (rst || start) begin
      hi_q      <= '0;
      phase_q   <= 1'b0;
      line_px_q <= 1'b0;
      xi_q      <= '0;
      tx_q      <= '0;
      x_done_q  <= 1'b0;
      yi_q      <= '0;
      ty_q      <= '0;
      y_done_q  <= 1'b0;
      for (int i = 0; i < NT; i++) cnt_q[i] <= '0;
`ifdef CAM_GREEN_STATS_EN
      tot_q     <= '0;
`endif
    end else if (href_fall) begin
      phase_q   <= 1'b0;
      line_px_q <= 1'b0;
      xi_q      <= '0;
      tx_q      <= '0;
      x_done_q  <= 1'b0;
      if (line_px_q && !y_done_q) begin
        yi_q <= yi_last ? '0 : yi_q + 1'b1;
        if (yi_last) begin
          ty_q     <= ty_last ? ty_q : ty_q + 1'b1;
          y_done_q <= ty_last;
        end
      end
    end else if (take && first) begin
      hi_q    <= d3_q;
      phase_q <= 1'b1;
    end else if (take) begin
      phase_q   <= 1'b0;
      line_px_q <= 1'b1;
      if (in_range) begin
        xi_q <= xi_last ? '0 : xi_q + 1'b1;
        if (xi_last) begin
          tx_q     <= tx_last ? tx_q : tx_q + 1'b1;
          x_done_q <= tx_last;
        end
        if (state_q == CAPTURE && green) begin
          for (int i = 0; i < NT; i++)
            if (i == tile_idx && cnt_q[i] != '1) cnt_q[i] <= cnt_q[i] + 1'b1;
`ifdef CAM_GREEN_STATS_EN
          if (tot_q != 16'hFFFF) tot_q <= tot_q + 16'd1;
`endif
        end
      end
    end else if (href_rise) begin
      phase_q <= 1'b0;
    end
  end

  // Threshold each tile count into its feature bit
  always_comb begin
    bits_d = '0;
    for (int i = 0; i < NT; i++) bits_d[i] = int'(cnt_q[i]) >= TILE_MIN;
  end

  // Frame control: wait for frame start, capture, evaluate once, hold until the consumer takes it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bits_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef CAM_GREEN_STATS_EN
      tot_out_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE:    if (vs_fall) state_q <= CAPTURE;
        CAPTURE: if (vs_rise) state_q <= EVAL;
        EVAL: begin
          bits_q    <= bits_d;
          err_q     <= err_q | !y_done_q;
          valid_q   <= 1'b1;
          state_q   <= HOLD;
`ifdef CAM_GREEN_STATS_EN
          tot_out_q <= tot_q;
`endif
        end
        default: begin
          if (feat_ready) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            state_q <= IDLE;
          end
          if (vs_fall) err_q <= 1'b1;
        end
      endcase
    end
  end

  assign feat_bits  = bits_q;
  assign feat_valid = valid_q;
  assign frame_err  = err_q;
`ifdef CAM_GREEN_STATS_EN
  assign green_total = tot_out_q;
`endif

endmodule

// File: tb/tb_cam_green_tiler.sv
// tb_cam_green_tiler: directed frame vectors plus hand-written corner sequences for cam_green_tiler
module tb_cam_green_tiler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cam_data = 8'h00;
  logic       cam_pclk = 1'b0;
  logic       cam_href = 1'b0;
  logic       cam_vsync = 1'b1;
  logic       feat_ready = 1'b0;
  logic [3:0] feat_bits;
  logic       feat_valid;
  logic       frame_err;
`ifdef CAM_GREEN_STATS_EN
  logic [15:0] green_total;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cam_green_tiler #(
    .IMG_W(8), .IMG_H(4), .TILES_X(2), .TILES_Y(2), .GREEN_MARGIN(4), .TILE_MIN(4)
  ) dut (
    .clk(clk), .rst(rst), .cam_data(cam_data), .cam_pclk(cam_pclk), .cam_href(cam_href),
    .cam_vsync(cam_vsync), .feat_bits(feat_bits), .feat_valid(feat_valid),
    .feat_ready(feat_ready), .frame_err(frame_err)
`ifdef CAM_GREEN_STATS_EN
    , .green_total(green_total)
`endif
  );

  typedef struct {
    int         k;
    int         nl;
    int         np;
    logic [3:0] bits;
    logic       err;
  } vec_t;

  vec_t tbl [8];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    cam_data = b;
    cam_pclk = 1'b0;
    cyc(3);
    cam_pclk = 1'b1;
    cyc(3);
    cam_pclk = 1'b0;
  endtask

  task automatic send_px(input bit g);
    send_byte(g ? 8'h3C : 8'hF8);
    send_byte(g ? 8'hA0 : 8'h00);
  endtask

  function automatic bit gpx(input int k, input int x, input int y);
    case (k)
      0:       return 1'b1;
      1:       return x < 4;
      2:       return x >= 8;
      3:       return (x < 4) == (y < 2);
      4:       return y == 0 && x < 3;
      5:       return y == 0 && x < 4;
      default: return y >= 4;
    endcase
  endfunction

  task automatic run_frame(input int k, input int nl, input int np, input bit lat);
    cam_vsync = 1'b0;
    cyc(6);
    for (int y = 0; y < nl; y++) begin
      cam_href = 1'b1;
      cyc(4);
      for (int x = 0; x < np; x++) send_px(gpx(k, x, y));
      cam_href = 1'b0;
      cyc(6);
    end
    cyc(2);
    cam_vsync = 1'b1;
    if (lat) begin
      cyc(4);
      chk("valid_before_5clk", 32'(feat_valid), 32'd0);
      cyc(1);
      chk("valid_at_5clk", 32'(feat_valid), 32'd1);
    end else begin
      cyc(8);
    end
  endtask

  task automatic handshake;
    feat_ready = 1'b1;
    cyc(1);
    feat_ready = 1'b0;
    chk("valid_after_hs", 32'(feat_valid), 32'd0);
    chk("err_after_hs", 32'(frame_err), 32'd0);
  endtask

  initial begin
    tbl[0] = '{0, 4, 8, 4'b1111, 1'b0};
    tbl[1] = '{1, 4, 8, 4'b0101, 1'b0};
    tbl[2] = '{0, 2, 8, 4'b0011, 1'b1};
    tbl[3] = '{2, 4, 10, 4'b0000, 1'b0};
    tbl[4] = '{3, 4, 8, 4'b1001, 1'b0};
    tbl[5] = '{4, 4, 8, 4'b0000, 1'b0};
    tbl[6] = '{5, 4, 8, 4'b0001, 1'b0};
    tbl[7] = '{6, 6, 8, 4'b0000, 1'b0};

    cyc(3);
    rst = 1'b0;
    cyc(1);
    chk("reset_bits", 32'(feat_bits), 32'd0);
    chk("reset_valid", 32'(feat_valid), 32'd0);
    chk("reset_err", 32'(frame_err), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_frame(tbl[i].k, tbl[i].nl, tbl[i].np, 1'b1);
      chk($sformatf("bits_vec%0d", i), 32'(feat_bits), 32'(tbl[i].bits));
      chk($sformatf("err_vec%0d", i), 32'(frame_err), 32'(tbl[i].err));
      handshake();
    end

    run_frame(0, 4, 8, 1'b1);
    run_frame(2, 4, 8, 1'b0);
    chk("drop_valid", 32'(feat_valid), 32'd1);
    chk("drop_bits", 32'(feat_bits), 32'hF);
    chk("drop_err", 32'(frame_err), 32'd1);
    handshake();

    cam_vsync = 1'b0;
    cyc(6);
    cam_href = 1'b1;
    cyc(4);
    for (int x = 0; x < 3; x++) send_px(1'b1);
    send_byte(8'h3C);
    cam_href = 1'b0;
    cyc(6);
    cam_href = 1'b1;
    cyc(4);
    send_px(1'b1);
    for (int x = 0; x < 3; x++) send_px(1'b0);
    cam_href = 1'b0;
    cyc(6);
    for (int y = 0; y < 2; y++) begin
      cam_href = 1'b1;
      cyc(4);
      for (int x = 0; x < 8; x++) send_px(1'b0);
      cam_href = 1'b0;
      cyc(6);
    end
    cam_vsync = 1'b1;
    cyc(8);
    chk("halfpx_bits", 32'(feat_bits), 32'b0001);
    chk("halfpx_err", 32'(frame_err), 32'd0);
    handshake();

    cam_vsync = 1'b0;
    cyc(6);
    for (int y = 0; y < 2; y++) begin
      cam_href = 1'b1;
      cyc(4);
      for (int x = 0; x < 8; x++) send_px(1'b1);
      cam_href = 1'b0;
      cyc(6);
    end
    chk("pre_rst_bits", 32'(feat_bits), 32'b0001);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("rst_bits", 32'(feat_bits), 32'd0);
    chk("rst_valid", 32'(feat_valid), 32'd0);
    chk("rst_err", 32'(frame_err), 32'd0);
    for (int y = 0; y < 2; y++) begin
      cam_href = 1'b1;
      cyc(4);
      for (int x = 0; x < 8; x++) send_px(1'b1);
      cam_href = 1'b0;
      cyc(6);
    end
    cam_vsync = 1'b1;
    cyc(10);
    chk("partial_no_valid", 32'(feat_valid), 32'd0);
    run_frame(0, 4, 8, 1'b1);
    chk("after_rst_bits", 32'(feat_bits), 32'hF);
    chk("after_rst_err", 32'(frame_err), 32'd0);
`ifdef CAM_GREEN_STATS_EN
    chk("green_total", 32'(green_total), 32'd32);
`endif
    handshake();

    feat_ready = 1'b1;
    run_frame(1, 4, 8, 1'b1);
    cyc(1);
    chk("ready_hi_pulse_end", 32'(feat_valid), 32'd0);
    chk("ready_hi_bits", 32'(feat_bits), 32'b0101);
    feat_ready = 1'b0;
    cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
